seg_byte_rx: RTL and testbench
==============================

SEG_BYTE_RX -- requirements
Module: seg_byte_rx

Parameters
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the number of clock cycles the block waits in WAIT_HI for the high-nibble code.

Interface
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port `seg`, input, 7 bits: active-low segment code, bit6=g … bit0=a.
REQ-005 The block SHALL have port `seg_stb`, input, 1 bit: `seg` is valid this cycle; `seg` is sampled only when `seg_stb`=1.
REQ-006 The block SHALL have port `byte_out`, output, 8 bits: last assembled byte, {high nibble, low nibble}.
REQ-007 The block SHALL have port `byte_vld`, output, 1 bit: one-cycle pulse when `byte_out` updates.
REQ-008 The block SHALL have port `err`, output, 1 bit: one-cycle pulse on an invalid code or a timeout.
REQ-009 The block SHALL have port `busy`, output, 1 bit: 1 while in WAIT_HI.
REQ-010 The block SHALL have port `err_cnt`, output, 8 bits: saturating count of `err` pulses.

Function
REQ-011 The block SHALL decode `seg` by exact match with this table; any other code is invalid:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-012 The block SHALL implement a two-state machine: IDLE and WAIT_HI.
REQ-013 In IDLE, `seg_stb`=1 with a valid code SHALL store the decoded nibble as the low nibble, clear the timeout counter and move to WAIT_HI.
REQ-014 In IDLE, `seg_stb`=1 with an invalid code SHALL pulse `err` and keep the state in IDLE.
REQ-015 In WAIT_HI, `seg_stb`=1 with a valid code SHALL load `byte_out` with {decoded nibble, stored low}, pulse `byte_vld` and return to IDLE.
REQ-016 In WAIT_HI, `seg_stb`=1 with an invalid code SHALL pulse `err`, discard the stored low nibble, leave `byte_out` unchanged and return to IDLE.
REQ-017 In WAIT_HI, the timeout counter SHALL increment on every cycle with `seg_stb`=0.
REQ-018 When the timeout counter equals TIMEOUT-1 and `seg_stb`=0, the block SHALL pulse `err` on the next cycle and return to IDLE; the counter is wide enough for TIMEOUT with no wrap.
REQ-019 If `seg_stb` arrives on the cycle the timeout would fire, the strobe SHALL take precedence and no timeout `err` SHALL occur.
REQ-020 `byte_vld`, `err` and `busy` SHALL be registered outputs; `byte_vld`/`err` assert in the cycle after the sampling edge and last exactly one cycle.
REQ-021 Throughput SHALL be one byte per two strobes, with back-to-back strobes accepted on consecutive cycles.
REQ-022 `byte_out` SHALL hold its value until the next successful byte.
REQ-023 `err_cnt` SHALL increment by 1 per `err` pulse and saturate at 255.
REQ-024 `byte_vld` and `err` SHALL never assert in the same cycle.

Reset
REQ-025 When `rst`=1, the block SHALL immediately force state=IDLE, `byte_out`=0x00, `byte_vld`=0, `err`=0, `busy`=0, `err_cnt`=0, timeout counter=0 and stored low nibble=0.
REQ-026 Reset asserted in WAIT_HI SHALL discard the partial byte, with no `err` pulse and no `byte_vld`.
REQ-027 The first strobe after reset release SHALL be treated as a low nibble.

Verification
REQ-028 Valid byte: strobe 0010010 ("5") then 0001000 ("A") on consecutive cycles -> `byte_out`=0xA5, `byte_vld` pulses once, `busy` 1 for one cycle, `err` 0.
REQ-029 Invalid code: strobe 1111111 in IDLE -> `err` pulses once, `err_cnt`=1, `busy` stays 0; then strobes "3","C" -> `byte_out`=0xC3.
REQ-030 Timeout (TIMEOUT=4): strobe "1", no further strobe -> `err` pulses 5 cycles after the strobe edge, `busy` falls, `byte_out` unchanged.
REQ-031 Timeout race (TIMEOUT=4): strobe "F", then strobe "0" exactly on the timeout cycle -> `byte_out`=0x0F, `byte_vld` pulses, no `err`.
REQ-032 Reset mid-byte: strobe "7", assert `rst` for 1 cycle, then strobes "2","E" -> `byte_out`=0xE2 with no prior `byte_vld`, `err_cnt`=0.
REQ-033 Saturation: 300 invalid strobes -> `err_cnt`=255 and holds.

Source files
------------

// File: rtl/seg_byte_rx.sv
// seg_byte_rx
//   Assembles bytes from pairs of strobed 7-segment codes. The first valid
//   code supplies the low nibble and the second supplies the high nibble.
//   An invalid code, or a missing high nibble after TIMEOUT idle cycles,
//   raises a one-cycle error pulse. Errors are also tallied in a saturating
//   counter.
//
// Parameters
//   TIMEOUT  : idle cycles tolerated in WAIT_HI before a timeout error
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   seg      : [6:0] active-low segment code, bit6=g .. bit0=a
//   seg_stb  : seg is valid this cycle
//   byte_out : [7:0] last assembled byte {high, low}
//   byte_vld : one-cycle pulse when byte_out updates
//   err      : one-cycle pulse on invalid code or timeout
//   busy     : high while waiting for the high nibble
//   err_cnt  : [7:0] saturating count of err pulses
module seg_byte_rx #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       seg_stb,
    output logic [7:0] byte_out,
    output logic       byte_vld,
    output logic       err,
    output logic       busy,
    output logic [7:0] err_cnt
);

    // Wide enough to hold TIMEOUT itself, so the counter never wraps.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_HI = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       low_q, low_d;
    logic [7:0]       byte_q, byte_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             dec_ok;
    logic [3:0]       dec_nib;

    // Returns {valid, nibble}; anything outside the table is invalid.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    assign {dec_ok, dec_nib} = seg_decode(seg);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        low_d     = low_q;
        byte_d    = byte_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (seg_stb) begin
                    if (dec_ok) begin
                        low_d   = dec_nib;
                        cnt_d   = '0;
                        state_d = WAIT_HI;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT_HI: begin
                // A strobe always wins over a timeout landing on the same cycle.
                if (seg_stb) begin
                    state_d = IDLE;
                    if (dec_ok) begin
                        byte_d = {dec_nib, low_q};
                        vld_d  = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        low_d  = 4'h0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // busy is registered from the next state so it tracks WAIT_HI exactly.
        busy_d = (state_d == WAIT_HI);

        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            low_q     <= 4'h0;
            byte_q    <= 8'h00;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            low_q     <= low_d;
            byte_q    <= byte_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign byte_out = byte_q;
    assign byte_vld = vld_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_seg_byte_rx.sv
// tb_seg_byte_rx
//   Directed scenarios followed by randomized strobes, compared each cycle
//   against a reference model that tracks the pending low nibble and the
//   cycle on which it arrived.
module tb_seg_byte_rx;

    localparam int TO = 4;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic       seg_stb;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       err;
    logic       busy;
    logic [7:0] err_cnt;

    int checks;
    int errors;

    // Segment codes indexed by the hex digit they display.
    logic [6:0] codes [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model state
    bit         m_pending;
    logic [3:0] m_low;
    int         m_low_cyc;
    int         m_cyc;
    logic [7:0] m_byte;
    logic       m_vld;
    logic       m_err;
    int         m_cnt;

    seg_byte_rx #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg      (seg),
        .seg_stb  (seg_stb),
        .byte_out (byte_out),
        .byte_vld (byte_vld),
        .err      (err),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lookup(input logic [6:0] c);
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0;
        m_low     = 4'h0;
        m_byte    = 8'h00;
        m_vld     = 1'b0;
        m_err     = 1'b0;
        m_cnt     = 0;
    endtask

    // Expected outputs after one clock edge with the given inputs.
    task automatic model_step(input logic s, input logic [6:0] c);
        int idx;
        idx   = lookup(c);
        m_vld = 1'b0;
        m_err = 1'b0;
        if (s) begin
            if (idx < 0) begin
                m_err     = 1'b1;
                m_pending = 0;
            end else if (m_pending) begin
                m_byte    = {idx[3:0], m_low};
                m_vld     = 1'b1;
                m_pending = 0;
            end else begin
                m_pending = 1;
                m_low     = idx[3:0];
                m_low_cyc = m_cyc;
            end
        end else if (m_pending && (m_cyc - m_low_cyc) == TO) begin
            m_err     = 1'b1;
            m_pending = 0;
        end
        if (m_err && m_cnt < 255) m_cnt++;
        m_cyc++;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".byte_out"}, byte_out, m_byte);
        check({tag, ".byte_vld"}, {7'd0, byte_vld}, {7'd0, m_vld});
        check({tag, ".err"},      {7'd0, err},      {7'd0, m_err});
        check({tag, ".busy"},     {7'd0, busy},     {7'd0, m_pending});
        check({tag, ".err_cnt"},  err_cnt,          m_cnt[7:0]);
    endtask

    task automatic cycle(input string tag, input logic s, input logic [6:0] c);
        seg_stb = s;
        seg     = c;
        @(posedge clk);
        model_step(s, c);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst     = 1'b1;
        seg_stb = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        int vld_seen;
        int err_at;
        int busy_cycles;
        checks  = 0;
        errors  = 0;
        m_cyc   = 0;
        m_low_cyc = 0;
        rst     = 1'b1;
        seg     = 7'h7F;
        seg_stb = 1'b0;
        model_reset();

        // Reset state
        #2;
        check("rst.byte_out", byte_out, 8'h00);
        check("rst.err_cnt",  err_cnt,  8'h00);
        do_reset("rst");

        // Valid byte: "5" then "A" back to back
        vld_seen = 0;
        busy_cycles = 0;
        cycle("a5.lo", 1'b1, codes[5]);
        if (busy) busy_cycles++;
        cycle("a5.hi", 1'b1, codes[10]);
        if (byte_vld) vld_seen++;
        check("a5.byte", byte_out, 8'hA5);
        cycle("a5.idle", 1'b0, 7'h00);
        if (byte_vld) vld_seen++;
        if (busy) busy_cycles++;
        check("a5.vld_once", vld_seen[7:0], 8'd1);
        check("a5.busy_one", busy_cycles[7:0], 8'd1);

        // Invalid code in IDLE, then "3","C"
        cycle("inv.code", 1'b1, 7'b1111111);
        check("inv.err", {7'd0, err}, 8'd1);
        check("inv.busy", {7'd0, busy}, 8'd0);
        check("inv.err_cnt", err_cnt, 8'd1);
        cycle("c3.lo", 1'b1, codes[3]);
        cycle("c3.hi", 1'b1, codes[12]);
        check("c3.byte", byte_out, 8'hC3);
        cycle("c3.idle", 1'b0, 7'h00);

        // Timeout: "1" then silence; err in the fifth cycle after the strobe edge
        cycle("to.lo", 1'b1, codes[1]);
        err_at = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle("to.wait", 1'b0, 7'h00);
            if (err && err_at < 0) err_at = i + 1;
        end
        check("to.err_cycle", err_at[7:0], 8'd5);
        check("to.byte_kept", byte_out, 8'hC3);
        check("to.busy_low", {7'd0, busy}, 8'd0);

        // Timeout race: "F", three idle cycles, "0" on the timeout cycle
        cycle("race.lo", 1'b1, codes[15]);
        for (int i = 0; i < TO - 1; i++) cycle("race.wait", 1'b0, 7'h00);
        cycle("race.hi", 1'b1, codes[0]);
        check("race.byte", byte_out, 8'h0F);
        check("race.vld", {7'd0, byte_vld}, 8'd1);
        check("race.no_err", {7'd0, err}, 8'd0);
        cycle("race.after", 1'b0, 7'h00);
        check("race.no_late_err", {7'd0, err}, 8'd0);

        // Invalid code while waiting for the high nibble
        cycle("whi.lo", 1'b1, codes[9]);
        cycle("whi.bad", 1'b1, 7'b1010101);
        check("whi.byte_kept", byte_out, 8'h0F);
        cycle("whi.lo2", 1'b1, codes[4]);
        cycle("whi.hi2", 1'b1, codes[6]);
        check("whi.byte", byte_out, 8'h64);

        // Reset mid-byte: "7", reset, then "2","E"
        cycle("mid.lo", 1'b1, codes[7]);
        do_reset("mid.rst");
        vld_seen = 0;
        cycle("mid.lo2", 1'b1, codes[2]);
        if (byte_vld) vld_seen++;
        check("mid.no_early_vld", vld_seen[7:0], 8'd0);
        cycle("mid.hi2", 1'b1, codes[14]);
        check("mid.byte", byte_out, 8'hE2);
        check("mid.err_cnt", err_cnt, 8'd0);
        cycle("mid.idle", 1'b0, 7'h00);

        // Randomized strobes, valid and invalid codes, with idle gaps
        for (int i = 0; i < 600; i++) begin
            logic       s;
            logic [6:0] c;
            s = ($urandom_range(0, 9) < 5);
            if ($urandom_range(0, 9) < 8) c = codes[$urandom_range(0, 15)];
            else                          c = 7'($urandom);
            cycle("rnd", s, c);
            if ($urandom_range(0, 39) == 0) begin
                for (int j = 0; j < TO + 1; j++) cycle("rnd.gap", 1'b0, 7'h00);
            end
        end

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 7'b1111111);
        check("sat.cnt", err_cnt, 8'd255);
        for (int i = 0; i < 3; i++) cycle("sat.hold", 1'b0, 7'h00);
        check("sat.hold_cnt", err_cnt, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
